// File: rtl/frame_decode.sv
// frame_decode: serial frame receiver.
//
// serial_data/serial_clock arrive asynchronously and are brought into the
// clock domain with two-flop synchronizers. A rising edge of the synchronized
// serial clock samples one bit. While hunting, bits slide through a
// SYNC_BITS window until it matches SYNC_PATTERN. The following
// FRAME_BITS-SYNC_BITS bits then form the payload. The complete frame
// {SYNC_PATTERN, payload} is offered to a one-entry output holding register
// with a valid/ready handshake.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   serial_data         serial bit, valid at the serial_clock rising edge
//   serial_clock        serial bit clock (each phase >= 2 clock periods)
//   frame_ready         consumer takes the held frame when frame_valid=1
//   frame_valid         frame holds a complete, unaccepted frame
//   frame               captured frame, first-received bit in the MSB
//   overrun             one-cycle pulse: a completed frame was dropped
//   timeout             one-cycle pulse: a partial frame was abandoned
//   drop_count          saturating count of overrun + timeout pulses
//   busy                high while a payload is being received
module frame_decode #(
  parameter int                   FRAME_BITS     = 192,
  parameter int                   SYNC_BITS      = 32,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN   = 32'hAAAA_AAAA,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_data,
  input  logic                  serial_clock,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  overrun,
  output logic                  timeout,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  localparam int PAY_BITS = FRAME_BITS - SYNC_BITS;
  localparam int CNT_W    = $clog2(PAY_BITS + 1);
  localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // Synchronizers and edge detect
  logic sc_meta_reg, sc_sync_reg, sc_prev_reg;
  logic sd_meta_reg, sd_sync_reg;
  logic started_reg, armed_reg;

  // Receiver state
  state_t                state_reg;
  logic [SYNC_BITS-1:0]  window_reg;
  logic [PAY_BITS-1:0]   payload_reg;
  logic [CNT_W-1:0]      bit_count_reg;
  logic [IDLE_W-1:0]     idle_reg;

  // Output stage
  logic                  frame_valid_reg;
  logic [FRAME_BITS-1:0] frame_reg;
  logic                  overrun_reg;
  logic                  timeout_reg;
  logic [7:0]            drop_count_reg;

  logic                  bit_event;
  logic [SYNC_BITS-1:0]  window_shift;
  logic [PAY_BITS-1:0]   payload_shift;
  logic                  offer;
  logic                  accept;
  logic                  timeout_hit;
  logic                  drop;

  // started_reg marks that sc_meta_reg holds a real sample rather than its
  // reset value. The edge detector only arms once the serial clock has been
  // seen low after reset, so a line already high at reset release cannot
  // masquerade as a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sc_meta_reg <= 1'b0;
      sc_sync_reg <= 1'b0;
      sc_prev_reg <= 1'b0;
      sd_meta_reg <= 1'b0;
      sd_sync_reg <= 1'b0;
      started_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      sc_meta_reg <= serial_clock;
      sc_sync_reg <= sc_meta_reg;
      sc_prev_reg <= sc_sync_reg;
      sd_meta_reg <= serial_data;
      sd_sync_reg <= sd_meta_reg;
      started_reg <= 1'b1;
      if (started_reg && !sc_meta_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign bit_event = armed_reg & sc_sync_reg & ~sc_prev_reg;

  // New bit enters at the LSB of both shift registers.
  if (SYNC_BITS > 1) begin : g_window
    assign window_shift = {window_reg[SYNC_BITS-2:0], sd_sync_reg};
  end else begin : g_window_one
    assign window_shift = sd_sync_reg;
  end

  if (PAY_BITS > 1) begin : g_payload
    assign payload_shift = {payload_reg[PAY_BITS-2:0], sd_sync_reg};
  end else begin : g_payload_one
    assign payload_shift = sd_sync_reg;
  end

  // The last payload bit is being processed this cycle.
  assign offer = (state_reg == PAYLOAD) && bit_event &&
                 (bit_count_reg == CNT_W'(PAY_BITS - 1));

  // Idle counter would reach TIMEOUT_CYCLES on this edge.
  assign timeout_hit = (state_reg == PAYLOAD) && !bit_event &&
                       (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

  // A ready consumer frees the holding register on the same edge, so a new
  // frame may replace the one being accepted.
  assign accept = !frame_valid_reg || frame_ready;
  assign drop   = (offer && !accept) || timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= HUNT;
      window_reg      <= '0;
      payload_reg     <= '0;
      bit_count_reg   <= '0;
      idle_reg        <= '0;
      frame_valid_reg <= 1'b0;
      frame_reg       <= '0;
      overrun_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      drop_count_reg  <= '0;
    end else begin
      overrun_reg <= offer && !accept;
      timeout_reg <= timeout_hit;

      if (drop && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end

      if (offer && accept) begin
        frame_reg       <= {SYNC_PATTERN, payload_shift};
        frame_valid_reg <= 1'b1;
      end else if (frame_valid_reg && frame_ready) begin
        frame_valid_reg <= 1'b0;
      end

      case (state_reg)
        HUNT: begin
          if (bit_event) begin
            window_reg <= window_shift;
            if (window_shift == SYNC_PATTERN) begin
              state_reg     <= PAYLOAD;
              bit_count_reg <= '0;
              idle_reg      <= '0;
            end
          end
        end

        PAYLOAD: begin
          if (bit_event) begin
            payload_reg <= payload_shift;
            idle_reg    <= '0;
            if (offer) begin
              state_reg     <= HUNT;
              window_reg    <= '0;
              bit_count_reg <= '0;
            end else begin
              bit_count_reg <= bit_count_reg + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            state_reg     <= HUNT;
            window_reg    <= '0;
            bit_count_reg <= '0;
            idle_reg      <= '0;
          end else begin
            idle_reg <= idle_reg + IDLE_W'(1);
          end
        end

        default: state_reg <= HUNT;
      endcase
    end
  end

  assign frame_valid = frame_valid_reg;
  assign frame       = frame_reg;
  assign overrun     = overrun_reg;
  assign timeout     = timeout_reg;
  assign drop_count  = drop_count_reg;
  assign busy        = (state_reg == PAYLOAD);

endmodule

// File: tb/tb_frame_decode.sv
// tb_frame_decode: self-checking bench for frame_decode.
//
// Three instances share clock and reset:
//   dut_a  default parameters
//   dut_b  FRAME_BITS=16, SYNC_BITS=8, SYNC_PATTERN=8'hA5
//   dut_c  default parameters with TIMEOUT_CYCLES=16
// Expected frames come from a reference model that scans the transmitted
// bit stream for the sync pattern and slices off the payload that follows.
module tb_frame_decode;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic sd   [3];
  logic sck  [3];
  logic rdy  [3];

  logic         fv_a, ov_a, to_a, busy_a;
  logic [191:0] frame_a;
  logic [7:0]   dc_a;
  logic         fv_b, ov_b, to_b, busy_b;
  logic [15:0]  frame_b;
  logic [7:0]   dc_b;
  logic         fv_c, ov_c, to_c, busy_c;
  logic [191:0] frame_c;
  logic [7:0]   dc_c;

  frame_decode dut_a (
    .clock(clock), .reset(reset), .serial_data(sd[0]), .serial_clock(sck[0]),
    .frame_ready(rdy[0]), .frame_valid(fv_a), .frame(frame_a), .overrun(ov_a),
    .timeout(to_a), .drop_count(dc_a), .busy(busy_a)
  );

  frame_decode #(.FRAME_BITS(16), .SYNC_BITS(8), .SYNC_PATTERN(8'hA5)) dut_b (
    .clock(clock), .reset(reset), .serial_data(sd[1]), .serial_clock(sck[1]),
    .frame_ready(rdy[1]), .frame_valid(fv_b), .frame(frame_b), .overrun(ov_b),
    .timeout(to_b), .drop_count(dc_b), .busy(busy_b)
  );

  frame_decode #(.TIMEOUT_CYCLES(16)) dut_c (
    .clock(clock), .reset(reset), .serial_data(sd[2]), .serial_clock(sck[2]),
    .frame_ready(rdy[2]), .frame_valid(fv_c), .frame(frame_c), .overrun(ov_c),
    .timeout(to_c), .drop_count(dc_c), .busy(busy_c)
  );

  int errors = 0;
  int checks = 0;

  bit           stream_q [$];
  bit [191:0]   exp_q    [$];
  bit [191:0]   got_a    [$];
  bit [191:0]   got_b    [$];
  bit [191:0]   got_c    [$];
  int           vc_a = 0;
  int           ovn_a = 0, ovn_c = 0;
  int           ton_a = 0, ton_c = 0;

  // Observe outputs on the falling edge: accepted frames and pulse cycles.
  always @(negedge clock) begin
    if (!reset) begin
      if (fv_a && rdy[0]) got_a.push_back(frame_a);
      if (fv_b && rdy[1]) got_b.push_back({176'b0, frame_b});
      if (fv_c && rdy[2]) got_c.push_back(frame_c);
      if (fv_a) vc_a++;
      if (ov_a) ovn_a++;
      if (to_a) ton_a++;
      if (ov_c) ovn_c++;
      if (to_c) ton_c++;
    end
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One serial bit: 3 cycles low, then 3 cycles high. The bit is processed on
  // the third rising clock edge of the high phase; the task returns just after
  // that edge. Optionally raise frame_ready in the cycle before that edge.
  task automatic send_bit(input int sel, input bit b, input bit raise_rdy = 1'b0);
    sd[sel]  = b;
    sck[sel] = 1'b0;
    stream_q.push_back(b);
    repeat (3) @(posedge clock);
    #1 sck[sel] = 1'b1;
    repeat (2) @(posedge clock);
    #1 if (raise_rdy) rdy[sel] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input int sel, input bit [191:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(sel, w[i]);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) sck[i] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  function automatic bit [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: find each occurrence of the sync pattern in the bit stream
  // (never overlapping a previously completed frame) and take the next
  // fb-sb bits as its payload; a frame cut off by the end of the stream
  // produces nothing.
  task automatic run_model(input int sb, input int fb, input bit [63:0] pat);
    int start, e, pb;
    bit hit;
    bit [191:0] f;
    exp_q.delete();
    pb = fb - sb;
    start = 0;
    while (1) begin
      hit = 1'b0;
      for (e = start + sb; e <= stream_q.size(); e++) begin
        hit = 1'b1;
        for (int k = 0; k < sb; k++)
          if (stream_q[e - sb + k] != pat[sb - 1 - k]) hit = 1'b0;
        if (hit) break;
      end
      if (!hit || (e + pb > stream_q.size())) break;
      f = '0;
      for (int k = 0; k < sb; k++) f = {f[190:0], pat[sb - 1 - k]};
      for (int k = 0; k < pb; k++) f = {f[190:0], stream_q[e + k]};
      exp_q.push_back(f);
      start = e + pb;
    end
  endtask

  task automatic cmp_frames(input string tag, input bit [191:0] got [$], input int base);
    check({tag, "_count"}, 192'(got.size() - base), 192'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got.size())
        check($sformatf("%s_frame%0d", tag, i), got[base + i], exp_q[i]);
  endtask

  localparam bit [31:0]  SYNC_A = 32'hAAAA_AAAA;
  localparam bit [159:0] P0 = 160'hD391D391_0DFFFFFF_02391F9F_00C0_00C8_64500C25;

  bit [159:0] f1, f2, f3, f4, f5;
  bit [191:0] w;
  int base, vbase, obase, tbase, hit, n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sd[i] = 1'b0; sck[i] = 1'b0; rdy[i] = 1'b0;
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("reset_a_flags", {fv_a, ov_a, to_a, busy_a, dc_a}, '0);
    check("reset_a_frame", frame_a, '0);
    check("reset_b_flags", {fv_b, ov_b, to_b, busy_b, dc_b, frame_b}, '0);
    check("reset_c_flags", {fv_c, ov_c, to_c, busy_c, dc_c}, '0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Reference frame with the consumer always ready.
    stream_q.delete(); base = got_a.size(); vbase = vc_a;
    send_word(0, SYNC_A, 32);
    send_word(0, P0, 160);
    repeat (3) @(posedge clock);
    #1;
    run_model(32, 192, 64'(SYNC_A));
    cmp_frames("a1", got_a, base);
    check("a1_frame", frame_a, {SYNC_A, P0});
    check("a1_valid_cycles", 192'(vc_a - vbase), 192'd1);
    check("a1_drop_count", dc_a, 8'd0);

    // Random payloads preceded by random noise.
    stream_q.delete(); base = got_a.size();
    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) send_bit(0, 1'($urandom_range(0, 1)));
      send_word(0, SYNC_A, 32);
      send_word(0, rand160(), 160);
    end
    repeat (3) @(posedge clock);
    #1;
    run_model(32, 192, 64'(SYNC_A));
    cmp_frames("a2", got_a, base);

    // Two frames with the consumer stalled: first held, second dropped.
    do_reset();
    rdy[0] = 1'b0;
    base = got_a.size(); obase = ovn_a;
    f1 = rand160(); f2 = rand160();
    send_word(0, SYNC_A, 32); send_word(0, f1, 160);
    send_word(0, SYNC_A, 32); send_word(0, f2, 160);
    repeat (2) @(posedge clock);
    #1;
    check("a3_held_frame", frame_a, {SYNC_A, f1});
    check("a3_held_valid", fv_a, 1'b1);
    check("a3_overrun_cycles", 192'(ovn_a - obase), 192'd1);
    check("a3_drop_count", dc_a, 8'd1);

    // Consumer becomes ready in the very cycle the next frame completes.
    f3 = rand160();
    w = {SYNC_A, f3};
    send_word(0, w >> 1, 191);
    send_bit(0, w[0], 1'b1);
    check("a4_frame_loaded", frame_a, w);
    check("a4_valid_kept", fv_a, 1'b1);
    check("a4_no_overrun", ov_a, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("a4_accepted_count", 192'(got_a.size() - base), 192'd2);
    if (got_a.size() >= base + 2) begin
      check("a4_first_accepted", got_a[base], {SYNC_A, f1});
      check("a4_second_accepted", got_a[base + 1], w);
    end
    check("a4_overrun_cycles", 192'(ovn_a - obase), 192'd1);
    check("a4_valid_cleared", fv_a, 1'b0);

    // Reset in the middle of a payload, then a clean frame.
    do_reset();
    rdy[0] = 1'b1;
    f4 = rand160();
    send_word(0, SYNC_A, 32);
    send_word(0, f4, 50);
    check("a5_busy_mid_frame", busy_a, 1'b1);
    obase = ovn_a; tbase = ton_a;
    do_reset();
    check("a5_after_reset", {busy_a, fv_a, dc_a, frame_a}, '0);
    stream_q.delete(); base = got_a.size();
    f4 = rand160();
    send_word(0, SYNC_A, 32); send_word(0, f4, 160);
    repeat (3) @(posedge clock);
    #1;
    run_model(32, 192, 64'(SYNC_A));
    cmp_frames("a5", got_a, base);
    check("a5_pulses", 192'((ovn_a - obase) + (ton_a - tbase)), 192'd0);
    check("a5_drop_count", dc_a, 8'd0);

    // Short sync word: noise, then A5 7E.
    stream_q.delete(); base = got_b.size();
    send_word(1, 8'h3C, 8);
    check("b1_noise_no_frame", 192'(got_b.size() - base), 192'd0);
    check("b1_noise_not_busy", busy_b, 1'b0);
    send_word(1, 8'hA5, 8);
    send_word(1, 8'h7E, 8);
    repeat (3) @(posedge clock);
    #1;
    run_model(8, 16, 64'hA5);
    cmp_frames("b1", got_b, base);
    check("b1_frame", frame_b, 16'hA57E);

    // Random noise bytes interleaved with frames.
    stream_q.delete(); base = got_b.size();
    for (int it = 0; it < 6; it++) begin
      send_word(1, 192'($urandom_range(0, 255)), 8);
      send_word(1, 8'hA5, 8);
      send_word(1, 192'($urandom_range(0, 255)), 8);
    end
    repeat (3) @(posedge clock);
    #1;
    run_model(8, 16, 64'hA5);
    cmp_frames("b2", got_b, base);

    // Serial clock stops after 10 payload bits.
    f5 = rand160();
    tbase = ton_c;
    send_word(2, SYNC_A, 32);
    send_word(2, f5, 10);
    check("c_busy_partial", busy_c, 1'b1);
    hit = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (to_c) begin
        hit = k;
        break;
      end
    end
    check("c_timeout_latency", 192'(hit), 192'd16);
    check("c_busy_after_timeout", busy_c, 1'b0);
    check("c_drop_count", dc_c, 8'd1);
    @(posedge clock);
    #1;
    check("c_timeout_cycles", 192'(ton_c - tbase), 192'd1);
    stream_q.delete(); base = got_c.size();
    f5 = rand160();
    send_word(2, SYNC_A, 32); send_word(2, f5, 160);
    repeat (3) @(posedge clock);
    #1;
    run_model(32, 192, 64'(SYNC_A));
    cmp_frames("c_after", got_c, base);
    check("c_drop_count_final", dc_c, 8'd1);
    check("c_no_overrun", 192'(ovn_c), 192'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_decode.md
FRAME_DECODE -- requirements
Module: frame_decode

Interface
REQ-001 Parameter FRAME_BITS, default 192: total frame length in bits, sync word included; legal range SYNC_BITS+1..1024.
REQ-002 Parameter SYNC_BITS, default 32: sync-word length in bits; legal range 1..64.
REQ-003 Parameter SYNC_PATTERN, default 32'hAAAA_AAAA: sync word, SYNC_BITS wide, first-received bit in the MSB.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: maximum clock cycles allowed between serial_clock rising edges inside a frame; legal range 4..65535.
REQ-005 clock  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 serial_data  input  1  asynchronous serial data, valid at serial_clock rising edge.
REQ-008 serial_clock  input  1  asynchronous serial bit clock; high and low phases each at least 2 clock periods.
REQ-009 frame_ready  input  1  consumer accepts the held frame in any cycle where frame_valid=1.
REQ-010 frame_valid  output  1  frame holds a complete, unaccepted frame.
REQ-011 frame  output  FRAME_BITS  captured frame; first-received bit in the MSB, sync word in the top SYNC_BITS.
REQ-012 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-013 timeout  output  1  one-cycle pulse when a partial frame is abandoned.
REQ-014 drop_count  output  8  saturating count of overrun plus timeout events.
REQ-015 busy  output  1  high while in state PAYLOAD.

Function
REQ-016 serial_clock and serial_data SHALL each pass through a two-flop synchronizer; a bit event SHALL occur in the single cycle where the synchronized clock is 1 and its previous registered value is 0.
REQ-017 On a bit event, the synchronized serial_data SHALL be the sampled bit; a level held high SHALL never produce more than one sample.
REQ-018 The FSM SHALL have two states, HUNT and PAYLOAD; the reset state SHALL be HUNT.
REQ-019 In HUNT, each sampled bit SHALL shift into a SYNC_BITS window (new bit at LSB); when the updated window equals SYNC_PATTERN, the FSM SHALL enter PAYLOAD with bit counter 0.
REQ-020 In PAYLOAD, each sampled bit SHALL shift into the payload register (new bit at LSB) and increment the bit counter; the sync window SHALL not be compared.
REQ-021 When the counter reaches FRAME_BITS-SYNC_BITS, the assembled frame {SYNC_PATTERN, payload} SHALL be offered to the output stage, the FSM SHALL return to HUNT, and the sync window SHALL be cleared to 0.
REQ-022 The output stage SHALL load frame and set frame_valid on the clock edge that processes the final bit event (third clock edge counting the edge that first samples serial_clock high as edge 1).
REQ-023 frame and frame_valid SHALL be held stable while frame_valid=1 and frame_ready=0.
REQ-024 frame_valid SHALL clear on the cycle after a cycle with frame_valid=1 and frame_ready=1, unless a new frame loads on that same edge.
REQ-025 Simultaneous frame_ready=1 and a new frame offer SHALL load the new frame, keep frame_valid=1, and not pulse overrun.
REQ-026 An offered frame while frame_valid=1 and frame_ready=0 SHALL be discarded, leave the held frame unchanged, and pulse overrun for one cycle.
REQ-027 In PAYLOAD, an idle counter SHALL reset to 0 on every bit event and increment otherwise; on reaching TIMEOUT_CYCLES, the FSM SHALL return to HUNT, clear the window and counter, and pulse timeout for one cycle.
REQ-028 drop_count SHALL increment by 1 on each overrun or timeout pulse and saturate at 255.
REQ-029 Sampling SHALL continue in HUNT while frame_valid=1, so the next sync word is found without waiting for frame_ready.

Reset
REQ-030 While reset=1, the FSM SHALL enter HUNT and the synchronizers, window, payload, counters, and frame SHALL be set to 0.
REQ-031 While reset=1, frame_valid, overrun, timeout, busy, and drop_count SHALL be 0.
REQ-032 Reset asserted mid-frame or mid-hold SHALL discard all partial and held data with no overrun or timeout pulse.
REQ-033 In the first cycle after reset, a serial_clock already high SHALL not produce a bit event.

Verification
REQ-034 Defaults, 0xAAAAAAAA then 160 payload bits 0xD391D391_0DFFFFFF_023 91F9F_00C0_00C8_64_50_0C_25, frame_ready=1 -> frame_valid one cycle, frame equals the 192-bit concatenation, drop_count=0.
REQ-035 SYNC_BITS=8, SYNC_PATTERN=8'hA5, FRAME_BITS=16: noise 0x3C, then 0xA5, 0x7E -> frame=16'hA57E; the noise produces no frame.
REQ-036 Two back-to-back frames with frame_ready=0 throughout -> the first frame is held, overrun pulses once at the second completion, drop_count=1.
REQ-037 TIMEOUT_CYCLES=16: serial_clock stopped after 10 payload bits -> timeout pulses exactly 16 cycles after the last bit event, busy=0, a following full frame decodes correctly.
REQ-038 frame_ready raised in the same cycle as the second frame completes -> second frame loaded, frame_valid stays 1, no overrun.
REQ-039 reset pulsed after 50 payload bits, then a full frame -> no pulses, correct frame, drop_count=0.
